ram_sync_dp: RTL and testbench

Parametrised simple-dual-port synchronous RAM: one write port, one read port, registered read data with a valid strobe, and a built-in clear sequencer that zeroes the whole array after reset or on request. It is the general-width and general-depth successor to the fixed 32 x 8 single-port RAM used in the clock/RAM experiments. It is intended as the shared storage primitive for later datapath and register-file work.

---
 rtl/ram_sync_dp_if.sv | 26 ++
 rtl/ram_sync_dp.sv | 94 +++++++++
 tb/tb_ram_sync_dp.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ram_sync_dp_if.sv
// Access bus for ram_sync_dp: clear request, one write port, one read port,
// and the registered read result with its valid strobe and the ready flag.
interface ram_sync_dp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              clr;
  logic              wena;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] datain;
  logic              rena;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] dataout;
  logic              rvalid;
  logic              ready;

  modport master (
    output clr, wena, waddr, datain, rena, raddr,
    input  dataout, rvalid, ready
  );

  modport slave (
    input  clr, wena, waddr, datain, rena, raddr,
    output dataout, rvalid, ready
  );
endinterface

// File: rtl/ram_sync_dp.sv
// Simple dual-port synchronous RAM with registered read data and a clear
// sequencer that zeroes every word after reset or on a clr request.
module ram_sync_dp #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int WRITE_FIRST = 0
) (
  input logic           clk,
  input logic           rst_n,
  ram_sync_dp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic              wr_hit;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= ptr_next;
    end
  end

  // The sweep owns the write port while clearing; user accesses only in RUN.
  always_comb begin
    state_next = state;
    ptr_next   = clr_ptr;
    mem_we     = 1'b0;
    mem_waddr  = bus.waddr;
    mem_wdata  = bus.datain;
    rd_en      = 1'b0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (clr_ptr == {ADDR_W{1'b1}}) begin
          state_next = RUN;
          ptr_next   = '0;
        end else begin
          ptr_next = clr_ptr + ADDR_W'(1);
        end
      end
      RUN: begin
        if (bus.clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else begin
          mem_we = bus.wena;
          rd_en  = bus.rena;
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage has no reset; writes are held off while rst_n is low.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n)
      mem[mem_waddr] <= mem_wdata;
  end

  assign wr_hit = mem_we && (bus.waddr == bus.raddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dataout <= '0;
      bus.rvalid  <= 1'b0;
    end else begin
      bus.rvalid <= rd_en;
      if (rd_en)
        bus.dataout <= ((WRITE_FIRST != 0) && wr_hit) ? bus.datain : mem[bus.raddr];
    end
  end

  assign bus.ready = (state == RUN);
endmodule

// File: tb/tb_ram_sync_dp.sv
// Randomized self-checking bench: a read-first and a write-first build run in
// lockstep against an array-based reference model of the RAM behaviour.
module tb_ram_sync_dp;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk;
  logic rst_n;

  ram_sync_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  ram_sync_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  ram_sync_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  ram_sync_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: contents, ready flag, sweep position, expected outputs.
  logic [DATA_W-1:0] mMem [DEPTH];
  bit                mReady;
  int                mSweep;
  bit                mValid;
  logic [DATA_W-1:0] mData0;
  logic [DATA_W-1:0] mData1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBoth(input string when);
    checkOutput({when, " ready0"},   32'(bus0.ready),   32'(mReady));
    checkOutput({when, " ready1"},   32'(bus1.ready),   32'(mReady));
    checkOutput({when, " rvalid0"},  32'(bus0.rvalid),  32'(mValid));
    checkOutput({when, " rvalid1"},  32'(bus1.rvalid),  32'(mValid));
    checkOutput({when, " dataout0"}, 32'(bus0.dataout), 32'(mData0));
    checkOutput({when, " dataout1"}, 32'(bus1.dataout), 32'(mData1));
  endtask

  // Called at a falling edge: drive, advance the model one edge, check.
  task automatic applyStimulus(input bit c, input bit w, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input bit r,
                               input logic [ADDR_W-1:0] ra);
    bus0.clr = c;  bus0.wena = w; bus0.waddr = wa; bus0.datain = wd;
    bus0.rena = r; bus0.raddr = ra;
    bus1.clr = c;  bus1.wena = w; bus1.waddr = wa; bus1.datain = wd;
    bus1.rena = r; bus1.raddr = ra;
    if (!mReady) begin
      mMem[mSweep] = '0;
      mSweep++;
      if (mSweep == DEPTH) begin
        mReady = 1'b1;
        mSweep = 0;
      end
      mValid = 1'b0;
    end else if (c) begin
      mReady = 1'b0;
      mSweep = 0;
      mValid = 1'b0;
    end else begin
      mValid = r;
      if (r) begin
        mData0 = mMem[ra];
        mData1 = (w && wa == ra) ? wd : mMem[ra];
      end
      if (w) mMem[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    checkBoth($sformatf("t=%0t", $time));
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    #1;
    mReady = 1'b0; mSweep = 0; mValid = 1'b0; mData0 = '0; mData1 = '0;
    checkBoth("reset immediate");
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Idles with ignored traffic until ready; the count is bounded.
  task automatic waitReady(output int edges);
    edges = 0;
    while (!bus0.ready && edges < 100) begin
      applyStimulus(1'b0, 1'b1, 5'd31, 8'hAA, 1'b1, 5'($urandom));
      edges++;
    end
  endtask

  int edges;

  initial begin
    rst_n = 1'b1;
    applyStimulusIdleInit();
    @(negedge clk);
    doReset(3);

    // Power-up sweep with writes to 31 that must be ignored.
    waitReady(edges);
    checkOutput("powerup ready latency", 32'(edges), 32'(DEPTH));

    applyStimulus(0, 0, 0, 0, 1, 5'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd1);
    applyStimulus(0, 0, 0, 0, 1, 5'd31);
    applyStimulus(0, 0, 0, 0, 0, 5'd0);

    applyStimulus(0, 1, 5'd1, 8'h24, 0, 5'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd1);
    applyStimulus(0, 0, 0, 0, 0, 5'd1);
    applyStimulus(0, 1, 5'd3, 8'h2C, 0, 5'd0);
    applyStimulus(0, 0, 0, 0, 1, 5'd3);

    // Same-address collision, then a plain follow-up read.
    applyStimulus(0, 1, 5'd3, 8'h5A, 1, 5'd3);
    applyStimulus(0, 0, 0, 0, 1, 5'd3);

    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 1, 5'(a), 8'hFF, 0, 5'd0);
    applyStimulus(1, 1, 5'd5, 8'h11, 0, 5'd0);
    waitReady(edges);
    checkOutput("clear ready-low edges", 32'(edges + 1), 32'(DEPTH + 1));
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 0, 1, 5'(a));

    // Abort a sweep at pointer 10 with reset.
    applyStimulus(1, 0, 0, 0, 0, 5'd0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 5'd0);
    doReset(3);
    waitReady(edges);
    checkOutput("midsweep reset ready latency", 32'(edges), 32'(DEPTH));

    for (int i = 0; i < 1500; i++) begin
      bit narrow;
      narrow = $urandom_range(0, 1) == 1;
      applyStimulus($urandom_range(0, 63) == 0, 1'($urandom), 
                    narrow ? 5'($urandom_range(0, 3)) : 5'($urandom),
                    8'($urandom), 1'($urandom),
                    narrow ? 5'($urandom_range(0, 3)) : 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  task automatic applyStimulusIdleInit();
    bus0.clr = 0; bus0.wena = 0; bus0.waddr = '0; bus0.datain = '0;
    bus0.rena = 0; bus0.raddr = '0;
    bus1.clr = 0; bus1.wena = 0; bus1.waddr = '0; bus1.datain = '0;
    bus1.rena = 0; bus1.raddr = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule
